// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Drives the PC mux select, the PC enable,
// the instruction-memory request and the IF/ID and ID/EX enable/flush controls.
// It arbitrates between EX redirects, memory wait states and load-use hazards.
// It also handles boot delay, memory-timeout halt and two saturating counters.
`timescale 1ns/1ps
module fetch_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_taken,
   input  logic             load_use,
   input  logic             imem_ready,
   output logic             pc_sel,
   output logic             pc_en,
   output logic             imem_req,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   // Boot counter holds BOOT_CYCLES; wait counter holds MEM_TIMEOUT-1.
   localparam int BW = $clog2(BOOT_CYCLES + 1);
   localparam int WW = $clog2(MEM_TIMEOUT);
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   boot_cnt;
   logic [WW-1:0]   wait_cnt;
   logic            boot_inc, wait_inc, wait_clr;
   logic            redirect_inc, stall_inc, err_set;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) return v;
      return v + CNT_W'(1);
   endfunction

   // State register; reset forces BOOT so every Mealy output drops at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= BOOT;
      else      state <= state_nxt;
   end

   // Next-state and Mealy control decode, redirect first, then memory, then load-use.
   always_comb begin
      state_nxt    = state;
      pc_sel       = 1'b0;
      pc_en        = 1'b0;
      imem_req     = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      halted       = 1'b0;
      boot_inc     = 1'b0;
      wait_inc     = 1'b0;
      wait_clr     = 1'b0;
      redirect_inc = 1'b0;
      stall_inc    = 1'b0;
      err_set      = 1'b0;
      case (state)
         BOOT: begin
            if (boot_cnt == BOOT_LAST) state_nxt = RUN;
            else                       boot_inc  = 1'b1;
         end
         RUN, MEM_WAIT: begin
            imem_req = 1'b1;
            if (br_taken) begin
               pc_sel       = 1'b1;
               pc_en        = 1'b1;
               ifid_en      = 1'b1;
               ifid_flush   = 1'b1;
               idex_flush   = 1'b1;
               redirect_inc = 1'b1;
               wait_clr     = 1'b1;
               state_nxt    = RUN;
            end else if (!imem_ready) begin
               // Not-ready: hold PC; either bubble ID/EX (load-use) or IF/ID.
               stall_inc = 1'b1;
               if (load_use) begin
                  idex_flush = 1'b1;
               end else begin
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
               end
               if (wait_cnt == WAIT_LAST) begin
                  state_nxt = HALT;
                  err_set   = 1'b1;
               end else begin
                  wait_inc  = 1'b1;
                  state_nxt = MEM_WAIT;
               end
            end else if (load_use) begin
               stall_inc  = 1'b1;
               idex_flush = 1'b1;
               wait_clr   = 1'b1;
               state_nxt  = RUN;
            end else begin
               pc_en     = 1'b1;
               ifid_en   = 1'b1;
               wait_clr  = 1'b1;
               state_nxt = RUN;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
      endcase
   end

   // Boot and memory-wait counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         boot_cnt <= '0;
         wait_cnt <= '0;
      end else begin
         if (boot_inc) boot_cnt <= boot_cnt + BW'(1);
         if (wait_clr)      wait_cnt <= '0;
         else if (wait_inc) wait_cnt <= wait_cnt + WW'(1);
      end
   end

   // Performance counters and the sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
         err          <= 1'b0;
      end else begin
         if (stall_inc)    stall_cnt    <= sat_inc(stall_cnt);
         if (redirect_inc) redirect_cnt <= sat_inc(redirect_cnt);
         if (err_set)      err          <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl. A behavioural model pushes
// the expected controls and counters for each driven cycle; each test task pops
// and compares them against the design mid-cycle.
`timescale 1ns/1ps
module tb_fetch_ctrl;
   localparam int BC   = 2;
   localparam int MT   = 16;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int VW   = 8 + 2 * CW;
   localparam int S_BOOT = 0, S_RUN = 1, S_MW = 2, S_HALT = 3;

   logic clk, rst, br_taken, load_use, imem_ready;
   logic pc_sel, pc_en, imem_req, ifid_en, ifid_flush, idex_flush, halted, err;
   logic [CW-1:0] stall_cnt, redirect_cnt;

   fetch_ctrl #(.BOOT_CYCLES(BC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .br_taken(br_taken), .load_use(load_use),
      .imem_ready(imem_ready), .pc_sel(pc_sel), .pc_en(pc_en),
      .imem_req(imem_req), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .halted(halted), .err(err),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   logic [VW-1:0] sb[$];
   logic [VW-1:0] exp_v;
   int nvec = 0;
   int nmis = 0;

   // Model state: elapsed boot edges, consecutive not-ready cycles, counters.
   int m_state, m_boot, m_wait, m_stall, m_redir, m_err;
   int n_state, n_boot, n_wait, n_stall, n_redir, n_err;

   initial begin
      clk = 1'b1;
      #5;
      forever begin
         clk = ~clk;
         #5;
      end
   end

   function automatic logic [VW-1:0] obs();
      return {pc_sel, pc_en, imem_req, ifid_en, ifid_flush, idex_flush,
              halted, err, stall_cnt, redirect_cnt};
   endfunction

   task automatic model_reset();
      m_state = S_BOOT; m_boot = 0; m_wait = 0;
      m_stall = 0; m_redir = 0; m_err = 0;
   endtask

   task automatic model_eval(input logic br, input logic lu, input logic rdy);
      logic ps, pe, rq, ie, ifl, idf;
      {ps, pe, rq, ie, ifl, idf} = '0;
      n_state = m_state; n_boot = m_boot; n_wait = m_wait;
      n_stall = m_stall; n_redir = m_redir; n_err = m_err;
      if (m_state == S_BOOT) begin
         n_boot = m_boot + 1;
         if (n_boot >= BC) n_state = S_RUN;
      end else if (m_state != S_HALT) begin
         rq = 1'b1;
         if (br) begin
            {ps, pe, ie, ifl, idf} = 5'b11111;
            n_redir = (m_redir < CMAX) ? m_redir + 1 : CMAX;
            n_wait = 0; n_state = S_RUN;
         end else if (!rdy) begin
            if (lu) idf = 1'b1;
            else begin ie = 1'b1; ifl = 1'b1; end
            n_wait = m_wait + 1;
            if (n_wait == MT) begin n_state = S_HALT; n_err = 1; end
            else n_state = S_MW;
         end else if (lu) begin
            idf = 1'b1; n_wait = 0; n_state = S_RUN;
         end else begin
            pe = 1'b1; ie = 1'b1; n_wait = 0; n_state = S_RUN;
         end
         if (!pe) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      sb.push_back({ps, pe, rq, ie, ifl, idf, (m_state == S_HALT), (m_err != 0),
                    CW'(m_stall), CW'(m_redir)});
   endtask

   task automatic drive(input logic br, input logic lu, input logic rdy);
      @(negedge clk);
      br_taken = br; load_use = lu; imem_ready = rdy;
      model_eval(br, lu, rdy);
      #2;
   endtask

   task automatic commit();
      @(posedge clk);
      m_state = n_state; m_boot = n_boot; m_wait = n_wait;
      m_stall = n_stall; m_redir = n_redir; m_err = n_err;
   endtask

   task automatic test_reset();
      exp_v = '0;
      nvec++;
      if (obs() !== exp_v) begin
         nmis++;
         $display("FAIL reset_state: got %h want %h", obs(), exp_v);
      end
   endtask

   task automatic test_boot();
      logic [2:0] st [6] = '{3'b110, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      for (int i = 0; i < 6; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL boot[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_redirect();
      logic [2:0] st [3] = '{3'b001, 3'b101, 3'b001};
      for (int i = 0; i < 3; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL redirect[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_load_use();
      logic [2:0] st [3] = '{3'b011, 3'b001, 3'b001};
      for (int i = 0; i < 3; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL load_use[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_mem_wait();
      logic [2:0] st [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b001};
      for (int i = 0; i < 6; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL mem_wait[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] st [5] = '{3'b000, 3'b110, 3'b001, 3'b111, 3'b001};
      for (int i = 0; i < 5; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL simultaneous[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_back_to_back();
      logic br, lu, rdy;
      for (int i = 0; i < 40; i++) begin
         br  = ($urandom_range(0, 3) == 0);
         lu  = ($urandom_range(0, 3) == 0);
         rdy = ((i % 8) == 7) || ($urandom_range(0, 2) != 0);
         drive(br, lu, rdy);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL back_to_back[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   task automatic test_timeout();
      drive(1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front(); nvec++;
      if (obs() !== exp_v) begin
         nmis++;
         $display("FAIL timeout_pre: got %h want %h", obs(), exp_v);
      end
      commit();
      for (int i = 0; i < MT + 4; i++) begin
         if (i < MT) drive(1'b0, i[0], 1'b0);
         else        drive(1'b1, 1'b0, 1'b1);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL timeout[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
      #1;
      nvec++;
      if ({halted, err, imem_req, pc_en, stall_cnt} !== {4'b1100, 4'hF}) begin
         nmis++;
         $display("FAIL halt_state: got %b want %b",
                  {halted, err, imem_req, pc_en, stall_cnt}, {4'b1100, 4'hF});
      end
   endtask

   task automatic test_reset_recovery();
      logic [2:0] st [7] = '{3'b101, 3'b110, 3'b001, 3'b101, 3'b000, 3'b001, 3'b001};
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      exp_v = '0; nvec++;
      if (obs() !== exp_v) begin
         nmis++;
         $display("FAIL reset_async: got %h want %h", obs(), exp_v);
      end
      @(negedge clk); #1;
      nvec++;
      if (obs() !== exp_v) begin
         nmis++;
         $display("FAIL reset_held: got %h want %h", obs(), exp_v);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(st[i][2], st[i][1], st[i][0]);
         exp_v = sb.pop_front(); nvec++;
         if (obs() !== exp_v) begin
            nmis++;
            $display("FAIL recovery[%0d]: got %h want %h", i, obs(), exp_v);
         end
         commit();
      end
   endtask

   initial begin
      rst = 1'b0; br_taken = 1'b0; load_use = 1'b0; imem_ready = 1'b0;
      model_reset();
      #0.5;
      test_reset();
      #0.5;
      rst = 1'b1;
      test_boot();
      test_redirect();
      test_load_use();
      test_mem_wait();
      test_simultaneous();
      test_back_to_back();
      test_timeout();
      test_reset_recovery();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the fetch stage of the RISC-V pipeline. Each cycle it drives the fetch PC mux select (`pc_sel`), the PC register enable, the instruction-memory request, and the IF/ID and ID/EX enable/flush controls. It arbitrates between three events: branch/jump redirects from EX, instruction-memory wait states, and load-use hazards from ID. It also handles boot sequencing after reset, a memory-timeout halt, and two performance counters.

## Interface
- `BOOT_CYCLES`, default 2: idle cycles after reset release before the first fetch (≥1).
- `MEM_TIMEOUT`, default 16: consecutive not-ready cycles tolerated before halting (≥2).
- `CNT_W`, default 32: width of the performance counters.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `br_taken` input 1: EX redirect request; the ALU target is valid on the fetch `alu_in`.
- `load_use` input 1: ID load-use hazard detected.
- `imem_ready` input 1: instruction memory returns a valid word this cycle for the current request.
- `pc_sel` output 1: 1 selects the ALU target, 0 selects PC+4.
- `pc_en` output 1: PC register load enable.
- `imem_req` output 1: instruction fetch request.
- `ifid_en` output 1: IF/ID register load enable.
- `ifid_flush` output 1: IF/ID register loads a NOP.
- `idex_flush` output 1: ID/EX register loads a NOP.
- `halted` output 1: controller is in HALT.
- `err` output 1: sticky memory-timeout flag.
- `stall_cnt` output CNT_W: cycles with `pc_en`=0 while in RUN/MEM_WAIT.
- `redirect_cnt` output CNT_W: accepted redirects.

## Operation
- States are BOOT, RUN, MEM_WAIT and HALT. Outputs are Mealy: a function of state and inputs.
- **BOOT:** all control outputs are 0. The boot counter counts `BOOT_CYCLES` cycles, then the state goes to RUN. `br_taken`, `load_use` and `imem_ready` are ignored.
- **RUN / MEM_WAIT:** `imem_req`=1. Priority order, first match wins:
  1. **`br_taken`=1:** `pc_sel`=1, `pc_en`=1, `ifid_flush`=1, `idex_flush`=1, `ifid_en`=1. `redirect_cnt` increments. The wait counter clears. Next state is RUN, regardless of `imem_ready` or `load_use`.
  2. **`imem_ready`=0 with `load_use`=1:** `pc_en`=0, `ifid_en`=0, `ifid_flush`=0, `idex_flush`=1. The wait counter increments. Next state is MEM_WAIT.
  3. **`imem_ready`=0 with `load_use`=0:** `pc_en`=0, `ifid_en`=1, `ifid_flush`=1, `idex_flush`=0. The wait counter increments. Next state is MEM_WAIT.
  4. **`load_use`=1 (memory ready):** `pc_en`=0, `ifid_en`=0, `ifid_flush`=0, `idex_flush`=1. The wait counter clears. Next state is RUN.
  5. **Otherwise:** `pc_en`=1, `ifid_en`=1, `pc_sel`=0, both flushes 0. The wait counter clears. Next state is RUN.
- **Timeout:** applies in cases 2 and 3. If the wait counter equals `MEM_TIMEOUT`-1 before incrementing, the next state is HALT and `err` is set.
- **HALT:** all control outputs are 0 and `halted`=1. The only exit is reset.
- **Counters:**
  - `stall_cnt` increments in every RUN/MEM_WAIT cycle where `pc_en`=0.
  - Both counters saturate at all-ones; they never wrap.
  - Neither counter changes in BOOT or HALT.
- **Widths:** the wait counter is sized to hold `MEM_TIMEOUT`-1; the boot counter is sized to hold `BOOT_CYCLES`.

## Timing
- **Reset (asynchronous, active-low):** while `rst`=0, all outputs are 0 immediately: `pc_sel`, `pc_en`, `imem_req`, `ifid_en`, `ifid_flush`, `idex_flush`, `halted`, `err`, `stall_cnt`, `redirect_cnt`. State is BOOT and all counters are 0.
- **Reset mid-operation:** in any state, an asserted reset aborts immediately. After release the controller restarts with the full BOOT sequence.
- **First fetch:** after the first rising edge with `rst`=1, `imem_req` rises after exactly `BOOT_CYCLES` edges.
- **Latency:** zero-cycle combinational response from inputs to controls within the same cycle. State, counters and `err` update on the next rising edge.
- **Redirect:** PC loads the target on the edge ending the `br_taken` cycle. The redirect costs exactly 2 bubbles (IF/ID and ID/EX flushed).
- **Load-use:** each `load_use` cycle freezes the PC and IF/ID and inserts one ID/EX bubble.
- **Memory stall:** every not-ready cycle freezes the PC. The PC advances on the first ready cycle.

## Test plan
- **Boot:** release `rst` at t=1ns with `BOOT_CYCLES`=2 → `imem_req`=`pc_en`=0 for 2 edges, then `pc_en`=1 and `pc_sel`=0 on every cycle with `imem_ready`=1. Both counters stay 0.
- **Redirect:** pulse `br_taken` for 1 cycle in RUN → that cycle `pc_sel`=1, `pc_en`=1, `ifid_flush`=`idex_flush`=1. Next cycle `pc_sel`=0. `redirect_cnt`=1.
- **Load-use:** `load_use`=1 for 1 cycle with `imem_ready`=1 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for that cycle only. `stall_cnt`=1.
- **Memory wait:** `imem_ready`=0 for 3 cycles, then 1 → 3 cycles of `pc_en`=0, `ifid_flush`=1, state MEM_WAIT, then back to RUN with `pc_en`=1. `stall_cnt`=3.
- **Simultaneous events:** `br_taken`=`load_use`=1 with `imem_ready`=0 → redirect wins (`pc_sel`=1, `pc_en`=1), next state RUN, `stall_cnt` unchanged.
- **Timeout and reset recovery:** hold `imem_ready`=0 with `MEM_TIMEOUT`=16 → `halted`=`err`=1 after the 16th not-ready edge. After that, `br_taken` is ignored. Assert `rst`=0 mid-HALT → all outputs 0 immediately, and the BOOT sequence repeats after release.
